arbiter_control: RTL and testbench

- Control FSM for the I/D-to-L2 arbiter. Sits directly upstream of the arbiter datapath and drives its `arbiter_sel`.
- Decides whether the I-cache or the D-cache miss path owns the shared L2 port.
- Holds that ownership stable until L2 responds, and steers `l2_mem_resp` back to the owning cache.
- Round-robin on conflicts; sticky watchdog flag for hung transactions.

---
 rtl/lc3b_types.sv | 9 +
 rtl/arbiter_control.sv | 109 ++++++++++
 tb/tb_arbiter_control.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b types: arbiter select encoding and arbiter control FSM state.
package lc3b_types;

    localparam logic ARB_SEL_I = 1'b0;
    localparam logic ARB_SEL_D = 1'b1;

    typedef enum logic {ARB_IDLE, ARB_BUSY} lc3b_arb_state;

endpackage

// File: rtl/arbiter_control.sv
// Control FSM for the I/D-to-L2 arbiter: grants the shared L2 port, holds the
// grant until L2 responds, steers the response back and watches for hangs.
module arbiter_control
    import lc3b_types::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_mem_read,
    input  logic                 i_mem_write,
    input  logic                 d_mem_read,
    input  logic                 d_mem_write,
    input  logic                 l2_mem_resp,
    output logic                 arbiter_sel,
    output logic                 i_mem_resp,
    output logic                 d_mem_resp,
    output logic                 arb_busy,
    output logic                 timeout_err,
    output logic [CNT_WIDTH-1:0] conflict_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] WD_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    lc3b_arb_state        state_q, state_d;
    logic                 sel_q, last_q;
    logic [CNT_WIDTH-1:0] wd_cnt;
    logic                 i_req, d_req, any_req, both_req, owner_req, winner;

    assign i_req     = i_mem_read | i_mem_write;
    assign d_req     = d_mem_read | d_mem_write;
    assign any_req   = i_req | d_req;
    assign both_req  = i_req & d_req;
    assign owner_req = (sel_q == ARB_SEL_D) ? d_req : i_req;

    // Ties alternate against the last side actually served.
    always_comb begin
        winner = sel_q;
        if (both_req)   winner = ~last_q;
        else if (i_req) winner = ARB_SEL_I;
        else if (d_req) winner = ARB_SEL_D;
    end

    always_comb begin
        state_d     = state_q;
        arbiter_sel = ARB_SEL_I;
        i_mem_resp  = 1'b0;
        d_mem_resp  = 1'b0;
        arb_busy    = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                arbiter_sel = winner;
                if (any_req) begin
                    if (l2_mem_resp) begin
                        i_mem_resp = (winner == ARB_SEL_I);
                        d_mem_resp = (winner == ARB_SEL_D);
                    end else begin
                        state_d = ARB_BUSY;
                    end
                end
            end
            ARB_BUSY: begin
                arbiter_sel = sel_q;
                arb_busy    = 1'b1;
                i_mem_resp  = l2_mem_resp & (sel_q == ARB_SEL_I);
                d_mem_resp  = l2_mem_resp & (sel_q == ARB_SEL_D);
                if (l2_mem_resp || !owner_req) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
        // Outputs are combinational from live inputs, so mask them while reset is held.
        if (!rst_n) begin
            arbiter_sel = ARB_SEL_I;
            i_mem_resp  = 1'b0;
            d_mem_resp  = 1'b0;
            arb_busy    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ARB_IDLE;
            sel_q          <= ARB_SEL_I;
            last_q         <= ARB_SEL_D;
            wd_cnt         <= '0;
            timeout_err    <= 1'b0;
            conflict_count <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ARB_IDLE) begin
                if (any_req) begin
                    sel_q <= winner;
                    if (l2_mem_resp) last_q <= winner;
                    else             wd_cnt <= '0;
                end
                if (both_req && conflict_count != CNT_MAX)
                    conflict_count <= conflict_count + 1'b1;
            end else begin
                if (wd_cnt != CNT_MAX) wd_cnt <= wd_cnt + 1'b1;
                // Flag only; the grant is deliberately left in place.
                if (!l2_mem_resp && wd_cnt >= WD_LIMIT) timeout_err <= 1'b1;
                if (l2_mem_resp) last_q <= sel_q;
            end
        end
    end

endmodule

// File: tb/tb_arbiter_control.sv
// Directed plus randomized checks of arbiter_control against a transaction-level model.
module tb_arbiter_control;

    localparam int T  = 4;
    localparam int CW = 4;
    localparam int CC_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic i_mem_read = 1'b0, i_mem_write = 1'b0, d_mem_read = 1'b0, d_mem_write = 1'b0;
    logic l2_mem_resp = 1'b0;
    logic arbiter_sel, i_mem_resp, d_mem_resp, arb_busy, timeout_err;
    logic [CW-1:0] conflict_count;

    int vectors = 0;
    int miscompares = 0;

    // Model: who holds the port (if anyone), who was served last, how long the
    // current transaction has been waiting, and the event counters.
    bit m_held, m_owner, m_last, m_prev, m_to;
    int m_wait, m_conf;

    arbiter_control #(.TIMEOUT_CYCLES(T), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
        .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
        .l2_mem_resp(l2_mem_resp),
        .arbiter_sel(arbiter_sel), .i_mem_resp(i_mem_resp), .d_mem_resp(d_mem_resp),
        .arb_busy(arb_busy), .timeout_err(timeout_err), .conflict_count(conflict_count)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] observed();
        return {arbiter_sel, i_mem_resp, d_mem_resp, arb_busy, timeout_err, conflict_count};
    endfunction

    task automatic model_reset();
        m_held = 0; m_owner = 0; m_last = 1; m_prev = 0; m_to = 0; m_wait = 0; m_conf = 0;
    endtask

    function automatic bit pick(bit ir, bit dr);
        if (ir && dr) return !m_last;
        if (ir) return 1'b0;
        if (dr) return 1'b1;
        return m_prev;
    endfunction

    function automatic logic [8:0] expected(bit ir, bit dr, bit l2);
        bit side, done;
        side = m_held ? m_owner : pick(ir, dr);
        done = l2 && (m_held || ir || dr);
        return {side, done && !side, done && side, m_held, m_to, CW'(m_conf)};
    endfunction

    task automatic model_step(bit ir, bit dr, bit l2);
        bit side;
        if (!m_held) begin
            side = pick(ir, dr);
            if (ir && dr && m_conf < CC_MAX) m_conf++;
            if (ir || dr) begin
                m_prev = side;
                if (l2) m_last = side;
                else begin m_held = 1; m_owner = side; m_wait = 0; end
            end
        end else begin
            if (!l2 && m_wait >= T - 1) m_to = 1;
            m_wait++;
            if (l2) begin m_held = 0; m_last = m_owner; end
            else if (!(m_owner ? dr : ir)) m_held = 0;
        end
    endtask

    task automatic check(string tag, logic [8:0] obs, logic [8:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %b expected %b (sel,iresp,dresp,busy,to,cc)", tag, obs, exp);
        end
    endtask

    // Called at posedge+1: drive, check mid-cycle, then advance across the next edge.
    task automatic apply(string tag, bit ir, bit iw, bit dr, bit dw, bit l2);
        i_mem_read = ir; i_mem_write = iw; d_mem_read = dr; d_mem_write = dw; l2_mem_resp = l2;
        #3;
        check(tag, observed(), expected(ir | iw, dr | dw, l2));
        @(posedge clk); #1;
        model_step(ir | iw, dr | dw, l2);
    endtask

    // Reset pulse with inputs left as they are; l2 is forced high to expose any stray pulse.
    task automatic do_reset(string tag);
        l2_mem_resp = 1'b1;
        rst_n = 1'b0;
        #1;
        check(tag, observed(), 9'd0);
        @(posedge clk); #1;
        check({tag, "_held"}, observed(), 9'd0);
        rst_n = 1'b1;
        l2_mem_resp = 1'b0;
        model_reset();
    endtask

    initial begin
        bit ir, iw, dr, dw;
        model_reset();
        #2;
        check("reset", observed(), 9'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // I alone, L2 answers on the fourth cycle.
        for (int c = 0; c < 3; c++) apply("i_alone_wait", 1, 0, 0, 0, 0);
        apply("i_alone_resp", 1, 0, 0, 0, 1);
        apply("idle_gap", 0, 0, 0, 0, 0);

        do_reset("reset2");
        // Tie out of reset: I first, then D back-to-back, then a new tie goes to I.
        apply("tie_grant_i", 1, 0, 0, 1, 0);
        apply("tie_i_resp", 1, 0, 0, 1, 1);
        apply("tie_grant_d", 0, 0, 0, 1, 0);
        apply("tie_d_resp", 0, 0, 0, 1, 1);
        apply("tie_again", 1, 0, 1, 0, 0);
        apply("tie_again_resp", 1, 0, 1, 0, 1);
        apply("after_tie", 0, 0, 0, 0, 0);

        // D owns the port; I rises mid-transaction and must wait.
        apply("d_grant", 0, 0, 1, 0, 0);
        apply("d_hold_vs_i", 1, 0, 1, 0, 0);
        apply("d_hold_vs_i2", 1, 0, 1, 0, 0);
        apply("d_resp", 1, 0, 1, 0, 1);
        apply("i_after_d", 1, 0, 0, 0, 0);
        apply("i_after_d_resp", 1, 0, 0, 0, 1);

        // Same-cycle response in IDLE, then a tie must favour I; stray resp ignored.
        apply("d_instant", 0, 0, 1, 0, 1);
        apply("stray_resp", 0, 0, 0, 0, 1);
        apply("tie_after_instant", 1, 0, 1, 0, 1);

        // Owner abort, then simultaneous resp and owner drop.
        apply("abort_grant", 1, 0, 0, 0, 0);
        apply("abort_drop", 0, 0, 0, 0, 0);
        apply("abort_idle", 0, 0, 0, 0, 0);
        apply("drop_grant", 0, 0, 0, 1, 0);
        apply("drop_with_resp", 0, 0, 0, 0, 1);

        // Watchdog: I held with no response.
        for (int c = 0; c < T + 2; c++) apply("wd_wait", 1, 0, 0, 0, 0);
        apply("wd_late_resp", 1, 0, 0, 0, 1);
        apply("wd_sticky", 0, 0, 0, 0, 0);
        apply("wd_regrant", 0, 1, 0, 0, 0);
        do_reset("reset_mid_busy");

        // Conflict saturation.
        for (int c = 0; c < CC_MAX + 3; c++) apply("conf_sat", 1, 0, 1, 0, 1);
        do_reset("reset3");

        // Randomized traffic with occasional resets.
        ir = 0; iw = 0; dr = 0; dw = 0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(3) == 0) begin ir = $urandom_range(1); iw = ir ? 1'b0 : 1'($urandom_range(3) == 0); end
            if ($urandom_range(3) == 0) begin dr = $urandom_range(1); dw = dr ? 1'b0 : 1'($urandom_range(3) == 0); end
            apply("random", ir, iw, dr, dw, $urandom_range(4) == 0);
            if (c % 300 == 299) do_reset("random_reset");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
